// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling log2; callers guarantee value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v != 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full adder; maps onto the library full-adder cell.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract: operands shift LSB-first through one full-adder slice,
// carry held in a register between bits, valid/ready on both sides.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;
  logic             w_handoff;

  serial_fa_slice u_slice (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .c  (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_state == RUN) && (r_count == LastBit);
  assign w_handoff = (r_state == DONE) && r_out_valid && out_ready;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (w_handoff) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Subtraction as a + ~b + 1; cin is dropped in favour of the +1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_count <= '0;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_co;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_cout      <= w_co;
            r_ovf       <= r_carry ^ w_co;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (w_handoff) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed table, corner
// sequences and random operands against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         R;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .R         (R),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Two's-complement reference: subtraction is a + (-b) modulo 2^W.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic msub, output logic [W-1:0] s, output logic co,
                       output logic ov);
    logic [W-1:0] bv;
    logic [W:0]   tot;
    bv  = msub ? ~mb : mb;
    tot = {1'b0, ma} + {1'b0, bv} + (W+1)'(msub ? 1'b1 : mcin);
    s   = tot[W-1:0];
    co  = tot[W];
    ov  = (ma[W-1] == bv[W-1]) && (s[W-1] != ma[W-1]);
  endtask

  // Accept one operand set, wait for out_valid (bounded) and return results.
  // Leaves the DUT in DONE; caller performs the handoff.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic tsub, output int lat);
    @(negedge CLK);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    // Scramble inputs after accept; they must not matter.
    a = W'($urandom); b = W'($urandom); cin = ~tcin; sub = ~tsub;
    chk("busy_in_run", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk("idle_after_handoff", 32'({in_ready, out_valid, busy}), 32'b100);
  endtask

  task automatic full_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, input logic [W-1:0] es,
                         input logic ec, input logic eo);
    int lat;
    start_op(ta, tb, tcin, tsub, lat);
    chk({name, "_latency"}, 32'(lat), 32'(W));
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    handoff();
  endtask

  vec_t vecs[5];

  initial begin
    logic [W-1:0] ms, hs;
    logic         mc, mo, hc, ho;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           lat;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    R = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("reset_results", 32'({sum, cout, ovf}), 32'd0);
    @(negedge CLK);
    R = 1'b1;

    for (int i = 0; i < 5; i++) begin
      full_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
              vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
    end

    // Backpressure: results held, in_valid ignored while stalled in DONE.
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'(W));
    hs = sum; hc = cout; ho = ovf;
    chk("bp_sum_initial", 32'(hs), 32'h4B);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      @(posedge CLK); #1;
      chk("bp_hold", 32'({sum, cout, ovf}), 32'({hs, hc, ho}));
      chk("bp_flags", 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid = 1'b0;
    handoff();
    full_op("after_bp", 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);

    // out_ready already high when out_valid rises: consumed on the next edge.
    @(negedge CLK);
    out_ready = 1'b1;
    start_op(8'h40, 8'h40, 1'b0, 1'b0, lat);
    chk("early_rdy_latency", 32'(lat), 32'(W));
    chk("early_rdy_result", 32'({sum, cout, ovf}), 32'({8'h80, 1'b0, 1'b1}));
    @(posedge CLK); #1;
    chk("early_rdy_idle", 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b0;

    // Reset mid-RUN discards the partial result.
    @(negedge CLK);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    R = 1'b0;
    #1;
    chk("midrun_rst_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("midrun_rst_hold", 32'({in_ready, out_valid, busy}), 32'b100);
    @(negedge CLK);
    R = 1'b1;
    full_op("after_rst", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, ms, mc, mo);
      start_op(ra, rb, rc, rs, lat);
      chk("rand_latency", 32'(lat), 32'(W));
      chk("rand_result", 32'({sum, cout, ovf}), 32'({ms, mc, mo}));
      handoff();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
